// File: rtl/i2c_req_scheduler.sv
// Round-robin scheduler that funnels per-requester I2C byte transactions into a
// single byte-level master, with a WAIT watchdog that aborts a stuck transfer.
module i2c_req_scheduler #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic                 m_start,
  output logic                 m_rw,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_wdata,
  output logic                 m_abort,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata,
  output logic [2:0]           grant_id,
  output logic [2:0]           state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      last_q, last_d, gid_q, gid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rdy_q, rdy_d, rspv_q, rspv_d;
  logic [7:0]      rdata_q, rdata_d, wdata_q, wdata_d;
  logic [1:0]      err_q, err_d;
  logic            start_q, start_d, abort_q, abort_d, rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;

  logic            found;
  logic [2:0]      win;

  // First valid requester strictly after the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = 3'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    rdy_d   = '0;
    rspv_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          rdy_d   = NREQ'(1) << win;
          rw_d    = req_rw[win];
          addr_d  = req_addr[7*win +: 7];
          wdata_d = req_wdata[8*win +: 8];
          last_d  = win;
          gid_d   = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A completion on the final watchdog cycle still wins over the abort.
        if (m_done) begin
          err_d   = m_nack ? 2'b01 : 2'b00;
          rdata_d = (!m_nack && rw_q) ? m_rdata : 8'h00;
          state_d = RESP;
        end else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
          abort_d = 1'b1;
          err_d   = 2'b10;
          rdata_d = 8'h00;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rspv_d  = NREQ'(1) << gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'(NREQ - 1);
      gid_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= '0;
      rspv_q  <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      start_q <= start_d;
      abort_q <= abort_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rspv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_start   = start_q;
  assign m_abort   = abort_q;
  assign m_rw      = rw_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign grant_id  = gid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_i2c_req_scheduler.sv
// Scheduler bench: two instances (long and short watchdog) on shared stimulus,
// checked transaction-by-transaction against a round-robin/outcome model.
module tb_i2c_req_scheduler;
  localparam int N = 4;
  localparam int T = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_rw;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic           m_busy, m_done, m_nack;
  logic [7:0]     m_rdata;

  logic [N-1:0] rdy[2], rspv[2];
  logic [7:0]   rdat[2], mwd[2];
  logic [1:0]   err[2];
  logic         mst[2], mrw[2], mab[2];
  logic [6:0]   mad[2];
  logic [2:0]   gid[2], st[2];

  i2c_req_scheduler #(.NREQ(N), .TIMEOUT_CYCLES(1023)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
    .rsp_valid(rspv[0]), .rsp_rdata(rdat[0]), .rsp_err(err[0]),
    .m_start(mst[0]), .m_rw(mrw[0]), .m_addr(mad[0]), .m_wdata(mwd[0]),
    .m_abort(mab[0]), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata), .grant_id(gid[0]), .state(st[0]));

  i2c_req_scheduler #(.NREQ(N), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
    .rsp_valid(rspv[1]), .rsp_rdata(rdat[1]), .rsp_err(err[1]),
    .m_start(mst[1]), .m_rw(mrw[1]), .m_addr(mad[1]), .m_wdata(mwd[1]),
    .m_abort(mab[1]), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata), .grant_id(gid[1]), .state(st[1]));

  int n_chk = 0;
  int n_err = 0;
  int last_g[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic rand_fields();
    req_rw = N'($urandom);
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7]  = 7'($urandom);
      req_wdata[8*i +: 8] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    req_valid = '0; m_busy = 0; m_done = 0; m_nack = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_g[0] = N - 1;
    last_g[1] = N - 1;
  endtask

  // d: cycles after m_start before m_done is raised (<0 or >= watchdog: never).
  // rst_at: WAIT cycle at which reset is applied (<0: never).
  task automatic txn(input int s, input logic [N-1:0] mask, input int busy, input int d,
                     input logic nack, input logic [7:0] rd, input bit keep, input int rst_at);
    int w, lim, k, nwait, exp_err;
    bit ok, done_path;
    logic [6:0] ea;
    logic [7:0] ewd, exp_rd;
    logic erw;
    w = rr(last_g[s], mask);
    lim = s ? T : 1023;
    done_path = (d >= 0 && d < lim);
    req_valid = mask;
    m_busy = (busy > 0);
    ok = 0;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdy[s] != 0) begin ok = 1; break; end
    end
    if (!ok) begin chk("accept_timeout", 0, 1); return; end
    chk("accept_latency", k, 0);
    chk("req_ready", rdy[s], 1 << w);
    chk("grant_id", gid[s], w);
    chk("st_issue", st[s], 1);
    ea = req_addr[7*w +: 7]; ewd = req_wdata[8*w +: 8]; erw = req_rw[w];
    chk("m_addr", mad[s], ea);
    chk("m_wdata", mwd[s], ewd);
    chk("m_rw", mrw[s], erw);
    last_g[s] = w;
    if (!keep) req_valid = '0;
    for (k = 0; k < busy; k++) begin
      @(negedge clk);
      chk("busy_hold_st", st[s], 1);
      chk("busy_no_start", mst[s], 0);
    end
    m_busy = 0;
    @(negedge clk);
    chk("m_start", mst[s], 1);
    chk("st_wait", st[s], 2);
    chk("ready_pulse", rdy[s], 0);
    nwait = done_path ? d + 1 : lim;
    for (k = 0; k < nwait; k++) begin
      if (rst_at == k) begin
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_g[0] = N - 1; last_g[1] = N - 1;
        chk("rst_state", st[s], 0);
        chk("rst_rspv", rspv[s], 0);
        chk("rst_abort", mab[s], 0);
        chk("rst_maddr", mad[s], 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_rsp", rspv[s], 0);
          chk("rst_no_abort", mab[s], 0);
        end
        return;
      end
      if (done_path && k == d) begin
        m_done = 1; m_nack = nack; m_rdata = rd;
      end else if (!keep) begin
        req_valid = N'($urandom);
      end
      @(negedge clk);
      if (k < nwait - 1) begin
        chk("wait_st", st[s], 2);
        chk("wait_no_abort", mab[s], 0);
        chk("wait_no_ready", rdy[s], 0);
      end
    end
    m_done = 0;
    req_valid = keep ? mask : '0;
    exp_err = done_path ? (nack ? 1 : 0) : 2;
    exp_rd = (exp_err == 0 && erw) ? rd : 8'h00;
    chk("st_resp", st[s], 3);
    chk("rsp_err", err[s], exp_err);
    chk("rsp_rdata", rdat[s], exp_rd);
    chk("m_abort", mab[s], done_path ? 0 : 1);
    chk("rsp_early", rspv[s], 0);
    chk("m_addr_stable", mad[s], ea);
    chk("m_wdata_stable", mwd[s], ewd);
    chk("m_rw_stable", mrw[s], erw);
    @(negedge clk);
    chk("rsp_valid", rspv[s], 1 << w);
    chk("st_idle", st[s], 0);
    chk("abort_pulse", mab[s], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_busy = 0; m_done = 0; m_nack = 0; m_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", rdy[s], 0);   chk("rst_rsp_valid", rspv[s], 0);
      chk("rst_rdata", rdat[s], 0);  chk("rst_err", err[s], 0);
      chk("rst_mstart", mst[s], 0);  chk("rst_mabort", mab[s], 0);
      chk("rst_mrw", mrw[s], 0);     chk("rst_maddr0", mad[s], 0);
      chk("rst_mwdata", mwd[s], 0);  chk("rst_gid", gid[s], 0);
      chk("rst_st", st[s], 0);
    end
    rst = 1'b0;
    last_g[0] = N - 1; last_g[1] = N - 1;

    // Single read on the long-watchdog instance: done 20 cycles after m_start.
    req_rw = 4'b0100; req_addr[14 +: 7] = 7'h5A;
    txn(0, 4'b0100, 0, 20, 1'b0, 8'hC3, 1'b0, -1);

    // NACKed write from requester 0.
    do_reset();
    req_rw = 4'b0000; req_addr[0 +: 7] = 7'h5A; req_wdata[0 +: 8] = 8'h81;
    txn(1, 4'b0001, 0, 3, 1'b1, 8'h77, 1'b0, -1);

    // Fairness with every requester held valid.
    do_reset();
    rand_fields();
    for (int i = 0; i < 5; i++) begin
      txn(1, 4'hF, 0, int'($urandom_range(0, 5)), 1'b0, 8'($urandom), 1'b1, -1);
      chk("fair_order", last_g[1], i % N);
    end
    req_valid = '0;

    // Watchdog expiry, then completion on the final watchdog cycle.
    do_reset();
    rand_fields();
    txn(1, 4'b0010, 0, -1, 1'b0, 8'h00, 1'b0, -1);
    req_rw = 4'b0100;
    txn(1, 4'b0100, 0, T - 1, 1'b0, 8'h3C, 1'b0, -1);

    // Busy master for 5 cycles, then reset in WAIT; requester 0 first afterwards.
    txn(1, 4'b1000, 5, -1, 1'b0, 8'h00, 1'b0, 4);
    txn(1, 4'hF, 0, 2, 1'b0, 8'h5E, 1'b0, -1);
    chk("post_rst_first", last_g[1], 0);

    // Randomized traffic.
    repeat (60) begin
      logic [N-1:0] m;
      rand_fields();
      m = N'($urandom_range(1, (1 << N) - 1));
      txn(1, m, int'($urandom_range(0, 3)), int'($urandom_range(0, 17)),
          1'($urandom), 8'($urandom), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_req_scheduler.md
I2C_REQ_SCHEDULER -- requirements
Module: i2c_req_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum clk cycles in WAIT before abort.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester transaction request.
REQ-006 The block SHALL have port req_rw  input  NREQ  per-requester direction: 1 = read, 0 = write.
REQ-007 The block SHALL have port req_addr  input  7*NREQ  per-requester 7-bit slave address; requester i occupies bits [7i+6:7i].
REQ-008 The block SHALL have port req_wdata  input  8*NREQ  per-requester write byte; requester i occupies bits [8i+7:8i].
REQ-009 The block SHALL have port req_ready  output  NREQ  one-hot acceptance pulse.
REQ-010 The block SHALL have port rsp_valid  output  NREQ  one-hot completion pulse.
REQ-011 The block SHALL have port rsp_rdata  output  8  read byte; 0 for writes and errors.
REQ-012 The block SHALL have port rsp_err  output  2  completion status: 00 ok, 01 NACK, 10 timeout.
REQ-013 The block SHALL have port m_start  output  1  one-cycle command strobe to the byte-level I2C master.
REQ-014 The block SHALL have port m_rw  output  1  command direction.
REQ-015 The block SHALL have port m_addr  output  7  command address.
REQ-016 The block SHALL have port m_wdata  output  8  command write byte.
REQ-017 The block SHALL have port m_abort  output  1  one-cycle abort strobe to the master.
REQ-018 The block SHALL have port m_busy  input  1  master busy.
REQ-019 The block SHALL have port m_done  input  1  one-cycle master completion.
REQ-020 The block SHALL have port m_nack  input  1  slave NACK flag, valid with m_done.
REQ-021 The block SHALL have port m_rdata  input  8  read byte, valid with m_done.
REQ-022 The block SHALL have port grant_id  output  3  index of the current owner.
REQ-023 The block SHALL have port state  output  3  FSM state, for debug.

Function
REQ-024 The FSM SHALL have states IDLE=0, ISSUE=1, WAIT=2, RESP=3; encodings 4..7 SHALL be unused.
REQ-025 In IDLE with any req_valid set, the block SHALL select a winner round-robin, searching upward from last_grant+1 modulo NREQ.
REQ-026 On that same edge the block SHALL pulse req_ready[winner] for exactly one cycle, latch the winner's rw, addr and wdata, update last_grant and grant_id, and go to ISSUE.
REQ-027 In ISSUE with m_busy=0, the block SHALL pulse m_start for one cycle with the latched m_rw, m_addr and m_wdata, and go to WAIT.
REQ-028 In ISSUE with m_busy=1, the block SHALL hold ISSUE with m_start=0.
REQ-029 m_rw, m_addr and m_wdata SHALL stay stable from ISSUE entry until RESP exit.
REQ-030 WAIT SHALL clear a timeout counter on entry and increment it once per cycle.
REQ-031 In WAIT, m_done=1 SHALL cause a transition to RESP, capturing rsp_err=01 if m_nack=1, else 00.
REQ-032 On an ok read the block SHALL capture rsp_rdata=m_rdata; otherwise rsp_rdata SHALL be 0.
REQ-033 If the counter reaches TIMEOUT_CYCLES without m_done, the block SHALL pulse m_abort for one cycle, set rsp_err=10 and rsp_rdata=0, and go to RESP.
REQ-034 If m_done and timeout coincide, m_done SHALL take priority and no abort SHALL be issued.
REQ-035 In RESP the block SHALL pulse rsp_valid[grant_id] for exactly one cycle and return to IDLE.
REQ-036 Arbitration SHALL resume in the next IDLE cycle.
REQ-037 Minimum request-to-response latency SHALL be: accept at edge N, m_start at N+1, and rsp_valid at edge D+1, where D is the edge sampling m_done.
REQ-038 The block SHALL sample m_done, m_nack and m_rdata only in WAIT.
REQ-039 The block SHALL ignore req_valid outside IDLE.
REQ-040 A request dropped before acceptance SHALL never be granted.
REQ-041 At most one bit of req_ready and at most one bit of rsp_valid SHALL be set at any time.
REQ-042 With all NREQ requesters continuously valid, grants SHALL rotate 0,1,..,NREQ-1,0.

Reset
REQ-043 With rst=1 at a clk edge, the block SHALL set state=IDLE, last_grant=NREQ-1, grant_id=0, and the timeout counter to 0.
REQ-044 With rst=1 at a clk edge, the block SHALL drive req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_abort, m_rw, m_addr and m_wdata to 0.
REQ-045 Reset mid-transaction SHALL drop the transaction with no rsp_valid and no m_abort.
REQ-046 After reset, requester 0 SHALL have first priority.

Verification
REQ-047 Bench SHALL cover single read: req 2 read addr 0x5A; master done 20 cycles after m_start with m_rdata=0xC3, m_nack=0 -> rsp_valid=0100, rsp_rdata=0xC3, rsp_err=00.
REQ-048 Bench SHALL cover NACK write: req 0 write addr 0x5A, wdata 0x81; m_done with m_nack=1 -> rsp_err=01, rsp_rdata=0x00.
REQ-049 Bench SHALL cover fairness: all 4 requesters held valid after reset -> req_ready order 0,1,2,3,0 with one response per grant.
REQ-050 Bench SHALL cover timeout: TIMEOUT_CYCLES=15 and m_done never asserted -> m_abort pulse after 15 WAIT cycles, rsp_err=10.
REQ-051 Bench SHALL cover done/timeout coincidence: m_done on the 15th WAIT cycle -> rsp_err=00, m_abort stays 0.
REQ-052 Bench SHALL cover busy master and reset: m_busy=1 for 5 cycles holds ISSUE with no m_start; rst in WAIT -> IDLE next edge, no rsp_valid.
